branch_resolve_unit: RTL and testbench

- Registered, parametrised branch-condition unit for the MIPS pipeline, replacing the purely combinational sign/zero classifier.
- Evaluates eight branch conditions on two WIDTH-bit operands and classifies rs as zero, positive or negative.
- Keeps a DEPTH-entry table of 2-bit saturating predictors indexed by the low PC bits, flags mispredicts and counts them.
- Sits in ID/EX: inputs come from forwarded register values, outputs feed the PC-select and flush logic one cycle later.

---
 rtl/branch_resolve_unit.sv | 135 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Registered branch-condition unit for the ID/EX boundary. It resolves eight
// branch conditions, classifies rs, and tracks 2-bit predictors with a mispredict count.
module branch_resolve_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [IDX_W-1:0] pc_idx,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_pred,
  output logic             out_mispredict,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [2:0] {
    OP_BEQ    = 3'b000,
    OP_BNE    = 3'b001,
    OP_BLEZ   = 3'b010,
    OP_BGTZ   = 3'b011,
    OP_BLTZ   = 3'b100,
    OP_BGEZ   = 3'b101,
    OP_ALWAYS = 3'b110,
    OP_NEVER  = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'b00,
    CLS_POS  = 2'b01,
    CLS_NEG  = 2'b10
  } rs_class_e;

  logic [1:0]       r_ctr [DEPTH];
  logic             r_valid;
  logic             r_taken;
  logic             r_pred;
  logic [1:0]       r_class;
  logic [CNT_W-1:0] r_miss;

  logic             w_cap;
  logic             w_rs_zero;
  logic             w_rs_neg;
  logic             w_cond;
  logic [1:0]       w_class;
  logic [1:0]       w_ctr_rd;
  logic [1:0]       w_ctr_nxt;

  assign w_cap     = in_valid & ~stall & ~flush;
  assign w_rs_zero = (rs_val == '0);
  assign w_rs_neg  = rs_val[WIDTH-1];
  assign w_ctr_rd  = r_ctr[pc_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_cond = 1'b0;
    case (br_op)
      OP_BEQ:    w_cond = (rs_val == rt_val);
      OP_BNE:    w_cond = (rs_val != rt_val);
      OP_BLEZ:   w_cond = w_rs_neg | w_rs_zero;
      OP_BGTZ:   w_cond = ~w_rs_neg & ~w_rs_zero;
      OP_BLTZ:   w_cond = w_rs_neg;
      OP_BGEZ:   w_cond = ~w_rs_neg;
      OP_ALWAYS: w_cond = 1'b1;
      OP_NEVER:  w_cond = 1'b0;
      default:   w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_class = CLS_ZERO;
    if (!w_rs_zero) w_class = w_rs_neg ? CLS_NEG : CLS_POS;
  end

  always_comb begin
    w_ctr_nxt = w_ctr_rd;
    if (w_cond) begin
      if (w_ctr_rd != 2'b11) w_ctr_nxt = w_ctr_rd + 2'd1;
    end else begin
      if (w_ctr_rd != 2'b00) w_ctr_nxt = w_ctr_rd - 2'd1;
    end
  end

  // NOTE: the predictor table is a small flop array, so reset restores every entry;
  // a mid-run reset must leave no stale history behind.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_ctr[g] <= CTR_INIT;
      end else if (w_cap && (pc_idx == IDX_W'(g))) begin
        r_ctr[g] <= w_ctr_nxt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_pred  <= 1'b0;
      r_class <= 2'b00;
      r_miss  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_taken <= w_cond;
        r_pred  <= w_ctr_rd[1];
        r_class <= w_class;
        if (w_cond != w_ctr_rd[1]) r_miss <= r_miss + CNT_W'(1);
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_taken      = r_taken;
  assign out_pred       = r_pred;
  assign out_class      = r_class;
  assign out_mispredict = r_valid & (r_taken ^ r_pred);
  assign miss_cnt       = r_miss;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed corner sequences, a vector
// table and randomized traffic, all compared against a behavioural model.
module tb_branch_resolve_unit;

  localparam int WIDTH = 32;
  localparam int IDX_W = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, stall, flush;
  logic [2:0]        br_op;
  logic [WIDTH-1:0]  rs_val, rt_val;
  logic [IDX_W-1:0]  pc_idx;

  logic              out_valid, out_taken, out_pred, out_mispredict;
  logic [1:0]        out_class;
  logic [15:0]       miss_cnt;

  logic              b_valid, b_taken, b_pred, b_mispredict;
  logic [1:0]        b_class;
  logic [1:0]        b_miss;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CTR_INIT(2'b01), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .br_op(br_op), .rs_val(rs_val), .rt_val(rt_val), .pc_idx(pc_idx),
    .out_valid(out_valid), .out_taken(out_taken), .out_pred(out_pred),
    .out_mispredict(out_mispredict), .out_class(out_class), .miss_cnt(miss_cnt)
  );

  branch_resolve_unit #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CTR_INIT(2'b01), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .br_op(br_op), .rs_val(rs_val), .rt_val(rt_val), .pc_idx(pc_idx),
    .out_valid(b_valid), .out_taken(b_taken), .out_pred(b_pred),
    .out_mispredict(b_mispredict), .out_class(b_class), .miss_cnt(b_miss)
  );

  // Behavioural model: predictor strengths as plain integers 0..3.
  int          m_ctr [DEPTH];
  bit          m_valid, m_taken, m_pred;
  bit [1:0]    m_class;
  int unsigned m_miss;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          exp_taken;
    logic [1:0]  exp_class;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = $signed(rs);
    case (op)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return s <= 0;
      3'd3:    return s > 0;
      3'd4:    return s < 0;
      3'd5:    return s >= 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] ref_class(input logic [31:0] rs);
    int s;
    s = $signed(rs);
    if (rs == 0) return 2'b00;
    else if (s > 0) return 2'b01;
    else return 2'b10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
    m_valid = 0; m_taken = 0; m_pred = 0; m_class = 2'b00; m_miss = 0;
  endtask

  task automatic model_step();
    if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      if (in_valid) begin
        m_pred  = (m_ctr[pc_idx] >= 2);
        m_taken = ref_cond(br_op, rs_val, rt_val);
        m_class = ref_class(rs_val);
        if (m_taken != m_pred) m_miss++;
        if (m_taken) m_ctr[pc_idx] = (m_ctr[pc_idx] == 3) ? 3 : m_ctr[pc_idx] + 1;
        else         m_ctr[pc_idx] = (m_ctr[pc_idx] == 0) ? 0 : m_ctr[pc_idx] - 1;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".taken"}, out_taken, m_taken);
    check({tag, ".pred"},  out_pred,  m_pred);
    check({tag, ".mispredict"}, out_mispredict, m_valid & (m_taken ^ m_pred));
    check({tag, ".class"}, out_class, m_class);
    check({tag, ".miss"},  miss_cnt,  m_miss % 65536);
    check({tag, ".miss_w2"}, b_miss,  m_miss % 4);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic cap(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [3:0] idx, input string tag);
    in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    br_op = op; rs_val = rs; rt_val = rt; pc_idx = idx;
    cycle(tag);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h5,        32'h5, 1'b1, 2'b01};
    vecs[1]  = '{3'd0, 32'h5,        32'h6, 1'b0, 2'b01};
    vecs[2]  = '{3'd1, 32'h5,        32'h6, 1'b1, 2'b01};
    vecs[3]  = '{3'd1, 32'h0,        32'h0, 1'b0, 2'b00};
    vecs[4]  = '{3'd2, 32'h0,        32'h9, 1'b1, 2'b00};
    vecs[5]  = '{3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, 2'b10};
    vecs[6]  = '{3'd2, 32'h1,        32'h0, 1'b0, 2'b01};
    vecs[7]  = '{3'd3, 32'h0,        32'h0, 1'b0, 2'b00};
    vecs[8]  = '{3'd3, 32'h7FFFFFFF, 32'h0, 1'b1, 2'b01};
    vecs[9]  = '{3'd4, 32'h80000000, 32'h0, 1'b1, 2'b10};
    vecs[10] = '{3'd4, 32'h0,        32'h0, 1'b0, 2'b00};
    vecs[11] = '{3'd5, 32'h0,        32'h0, 1'b1, 2'b00};
    vecs[12] = '{3'd5, 32'h80000001, 32'h0, 1'b0, 2'b10};
    vecs[13] = '{3'd6, 32'h80000000, 32'h0, 1'b1, 2'b10};
    vecs[14] = '{3'd7, 32'h0,        32'h0, 1'b0, 2'b00};

    reset = 1'b1; in_valid = 0; stall = 0; flush = 0;
    br_op = 0; rs_val = 0; rt_val = 0; pc_idx = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all("reset");

    // Cold predictor at idx 3 mispredicts a taken BGEZ on zero.
    cap(3'd5, 32'h0, 32'h0, 4'd3, "t1");
    check("t1.valid_c", out_valid, 1); check("t1.taken_c", out_taken, 1);
    check("t1.pred_c", out_pred, 0);   check("t1.mis_c", out_mispredict, 1);
    check("t1.class_c", out_class, 0); check("t1.miss_c", miss_cnt, 1);

    for (int k = 0; k < 3; k++) begin
      cap(3'd0, 32'h1234, 32'h1234, 4'd3, "t2");
      check("t2.pred_c", out_pred, 1);
      check("t2.miss_c", miss_cnt, 1);
    end

    cap(3'd4, 32'h80000000, 32'h0, 4'd5, "t3a");
    check("t3a.pred_c", out_pred, 0); check("t3a.class_c", out_class, 2'b10);
    cap(3'd3, 32'h7FFFFFFF, 32'h0, 4'd5, "t3b");
    check("t3b.pred_c", out_pred, 1); check("t3b.class_c", out_class, 2'b01);
    cap(3'd7, 32'h0, 32'h0, 4'd5, "t3c");
    check("t3c.taken_c", out_taken, 0); check("t3c.pred_c", out_pred, 1);
    cap(3'd7, 32'h0, 32'h0, 4'd5, "t3d");
    check("t3d.pred_c", out_pred, 1); check("t3d.miss_c", miss_cnt, 4);
    check("t3d.miss_w2_c", b_miss, 0);

    // Stall holds everything, then flush wins over stall and in_valid.
    in_valid = 1; stall = 1; flush = 0; br_op = 3'd6; pc_idx = 4'd5;
    repeat (2) begin
      cycle("t4s");
      check("t4s.valid_c", out_valid, 1); check("t4s.miss_c", miss_cnt, 4);
    end
    flush = 1;
    cycle("t4f");
    check("t4f.valid_c", out_valid, 0); check("t4f.mis_c", out_mispredict, 0);
    cap(3'd6, 32'h0, 32'h0, 4'd5, "t4c");
    check("t4c.pred_c", out_pred, 0);
    check("t5.wrap_c", b_miss, 1);

    for (int i = 0; i < 15; i++) begin
      cap(vecs[i].op, vecs[i].rs, vecs[i].rt, 4'(i), "vec");
      check("vec.taken_c", out_taken, vecs[i].exp_taken);
      check("vec.class_c", out_class, vecs[i].exp_class);
    end

    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      br_op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       rs_val = 32'h0;
        1:       rs_val = 32'h80000000;
        2:       rs_val = 32'h7FFFFFFF;
        default: rs_val = $urandom;
      endcase
      rt_val = ($urandom_range(0, 1) != 0) ? rs_val : $urandom;
      pc_idx = 4'($urandom_range(0, 3));
      cycle("rand");
    end

    // Asynchronous reset between edges clears outputs at once and restores the table.
    cap(3'd6, 32'h1, 32'h0, 4'd2, "t6pre");
    check("t6pre.valid_c", out_valid, 1);
    in_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("t6.valid_async", out_valid, 0);
    check("t6.miss_async", miss_cnt, 0);
    check("t6.miss_w2_async", b_miss, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cap(3'd6, 32'h0, 32'h0, 4'(i), "t6tbl");
      check("t6tbl.pred_c", out_pred, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
